// File: rtl/dcache_port_arbiter.sv
// Shares one D$ request port between the store buffer, load unit and PTW.
// Uses round-robin arbitration with request locking and an in-order read-ID FIFO for response routing.
module dcache_port_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int ADDR_W          = 56,
    parameter int XLEN            = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ*XLEN-1:0]     wdata_i,
    input  logic [NUM_REQ*(XLEN/8)-1:0] be_i,
    input  logic [NUM_REQ*2-1:0]        size_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          rvalid_o,
    output logic [XLEN-1:0]             rdata_o,
    output logic                        dc_req_o,
    output logic                        dc_we_o,
    output logic [ADDR_W-1:0]           dc_addr_o,
    output logic [XLEN-1:0]             dc_wdata_o,
    output logic [XLEN/8-1:0]           dc_be_o,
    output logic [1:0]                  dc_size_o,
    input  logic                        dc_gnt_i,
    input  logic                        dc_rvalid_i,
    input  logic [XLEN-1:0]             dc_rdata_i,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = XLEN / 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     lock_idx_q;
    logic [IDX_W-1:0]     fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 err_q;

    logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
    logic [XLEN-1:0]      wdata_arr [NUM_REQ];
    logic [BE_W-1:0]      be_arr    [NUM_REQ];
    logic [1:0]           size_arr  [NUM_REQ];

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [NUM_REQ-1:0]   cand;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     head_idx;
    logic                 present;
    logic                 lock_drop;
    logic                 grant;
    logic                 push;
    logic                 pop;
    logic                 rsp_err;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (32'(idx) == 32'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = addr_i[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = wdata_i[i*XLEN +: XLEN];
            be_arr[i]    = be_i[i*BE_W +: BE_W];
            size_arr[i]  = size_i[i*2 +: 2];
        end
    end

    // Eligibility uses the registered count, so a same-cycle pop never frees a slot early.
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign cand       = req_i & (we_i | {NUM_REQ{~fifo_full}});
    assign head_idx   = fifo_q[rd_ptr_q];

    always_comb begin
        logic [IDX_W-1:0] k;
        win_found = 1'b0;
        win_idx   = '0;
        k         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IDX_W'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
            if (!win_found && cand[k]) begin
                win_found = 1'b1;
                win_idx   = k;
            end
        end
    end

    always_comb begin
        sel_idx   = win_idx;
        present   = 1'b0;
        lock_drop = 1'b0;
        if (!rst_i) begin
            if (state_q == LOCKED) begin
                sel_idx   = lock_idx_q;
                present   = req_i[lock_idx_q];
                lock_drop = ~req_i[lock_idx_q];
            end else begin
                present = win_found;
            end
        end
    end

    assign grant   = present & dc_gnt_i;
    assign push    = grant & ~we_i[sel_idx];
    assign pop     = ~rst_i & dc_rvalid_i & ~fifo_empty;
    assign rsp_err = dc_rvalid_i & fifo_empty;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (grant) begin
            gnt_o[sel_idx] = 1'b1;
        end
        if (pop) begin
            rvalid_o[head_idx] = 1'b1;
        end
    end

    assign rdata_o    = pop ? dc_rdata_i : '0;
    assign dc_req_o   = present;
    assign dc_we_o    = present & we_i[sel_idx];
    assign dc_addr_o  = present ? addr_arr[sel_idx] : '0;
    assign dc_wdata_o = present ? wdata_arr[sel_idx] : '0;
    assign dc_be_o    = present ? be_arr[sel_idx] : '0;
    assign dc_size_o  = present ? size_arr[sel_idx] : '0;
    assign busy_o     = ~fifo_empty | (state_q == LOCKED);
    assign err_o      = err_q;

    // Lock a presented-but-ungranted request so its fields stay on the port until the D$ accepts it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (present) begin
                        if (dc_gnt_i) begin
                            rr_ptr_q <= next_idx(win_idx);
                        end else begin
                            lock_idx_q <= win_idx;
                            state_q    <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (lock_drop) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (dc_gnt_i) begin
                        rr_ptr_q <= next_idx(lock_idx_q);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (rsp_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel_idx;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
